// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared single-port data memory (CPU data port vs UART loader).
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
//
// state  | meaning
// IDLE   | no access in flight; grant the winning request into owner
// ACCESS | memory enabled for the owner's access (memory samples at end of cycle)
// RESP   | owner's ack pulse, read data returned from m_rdata

module dmem_arbiter #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [3:0]    c_be,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_ack,
   output logic [DW-1:0] c_rdata,
   input  logic          u_req,
   input  logic          u_we,
   input  logic [3:0]    u_be,
   input  logic [AW-1:0] u_addr,
   input  logic [DW-1:0] u_wdata,
   output logic          u_ack,
   output logic [DW-1:0] u_rdata,
   output logic          m_en,
   output logic [3:0]    m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic OWN_CPU  = 1'b0;
   localparam logic OWN_UART = 1'b1;

   state_t state, state_nxt;
   logic   owner, owner_nxt;
   logic   grant;

`ifdef DMEM_ARB_RR_EN
   logic last_owner;

   // Ties go to whoever did not win last; resetting to UART hands the CPU the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_owner <= OWN_UART;
      else if (state == IDLE && (c_req || u_req))
         last_owner <= owner_nxt;
   end

   always_comb begin
      grant = OWN_CPU;
      if (c_req && u_req)
         grant = ~last_owner;
      else if (u_req)
         grant = OWN_UART;
   end
`else
   always_comb begin
      grant = c_req ? OWN_CPU : OWN_UART;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         owner <= OWN_CPU;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      case (state)
         IDLE: begin
            if (c_req || u_req) begin
               owner_nxt = grant;
               state_nxt = ACCESS;
            end
         end
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Owner's request fields are held stable by protocol, so muxing them here is safe.
   logic          sel_we;
   logic [3:0]    sel_be;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   assign sel_we    = (owner == OWN_UART) ? u_we    : c_we;
   assign sel_be    = (owner == OWN_UART) ? u_be    : c_be;
   assign sel_addr  = (owner == OWN_UART) ? u_addr  : c_addr;
   assign sel_wdata = (owner == OWN_UART) ? u_wdata : c_wdata;

   always_comb begin
      m_en    = 1'b0;
      m_we    = 4'b0000;
      m_addr  = '0;
      m_wdata = '0;
      c_ack   = 1'b0;
      c_rdata = '0;
      u_ack   = 1'b0;
      u_rdata = '0;
      case (state)
         ACCESS: begin
            m_en    = 1'b1;
            m_addr  = sel_addr;
            m_wdata = sel_wdata;
            m_we    = sel_we ? sel_be : 4'b0000;
         end
         RESP: begin
            if (owner == OWN_UART) begin
               u_ack   = 1'b1;
               u_rdata = u_we ? '0 : m_rdata;
            end else begin
               c_ack   = 1'b1;
               c_rdata = c_we ? '0 : m_rdata;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table of single accesses, hand sequences for arbitration,
// back-to-back re-request and reset mid-access; read data checked through per-port queues.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_req, c_we, u_req, u_we;
   logic [3:0]  c_be, u_be;
   logic [9:0]  c_addr, u_addr;
   logic [31:0] c_wdata, u_wdata;
   logic        c_ack, u_ack;
   logic [31:0] c_rdata, u_rdata;
   logic        m_en;
   logic [3:0]  m_we;
   logic [9:0]  m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] cq[$];
   logic [31:0] uq[$];

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(10), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack), .c_rdata(c_rdata),
      .u_req(u_req), .u_we(u_we), .u_be(u_be), .u_addr(u_addr), .u_wdata(u_wdata),
      .u_ack(u_ack), .u_rdata(u_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   // Synchronous single-port memory with byte lanes, read data one cycle after enable.
   logic [31:0] mem [0:1023];
   logic        mem_init;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++)
            mem[i] <= (i == 5) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i);
      end else if (m_en) begin
         for (int b = 0; b < 4; b++)
            if (m_we[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
         m_rdata <= mem[m_addr];
      end
   end

   // Requester protocol: a request not yet acked must still be high next cycle.
   logic c_pend, u_pend;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         c_pend <= 1'b0;
         u_pend <= 1'b0;
      end else begin
         assert (!(c_pend && !c_req)) else begin
            errors++;
            $display("FAIL c_req_hold: c_req dropped before ack");
         end
         assert (!(u_pend && !u_req)) else begin
            errors++;
            $display("FAIL u_req_hold: u_req dropped before ack");
         end
         c_pend <= c_req && !c_ack;
         u_pend <= u_req && !u_ack;
      end
   end

   // Scoreboard: each ack pops the expected read data; without ack, rdata must be 0.
   always @(negedge clk) begin
      logic [31:0] e;
      checks++;
      if (c_ack) begin
         if (cq.size() == 0) begin
            errors++;
            $display("FAIL c_ack_unexpected: c_ack=1 with nothing outstanding");
         end else begin
            e = cq.pop_front();
            if (c_rdata !== e) begin
               errors++;
               $display("FAIL c_rdata: got %08h expected %08h", c_rdata, e);
            end
         end
      end else if (c_rdata !== 32'h0) begin
         errors++;
         $display("FAIL c_rdata_idle: got %08h expected 00000000", c_rdata);
      end
      checks++;
      if (u_ack) begin
         if (uq.size() == 0) begin
            errors++;
            $display("FAIL u_ack_unexpected: u_ack=1 with nothing outstanding");
         end else begin
            e = uq.pop_front();
            if (u_rdata !== e) begin
               errors++;
               $display("FAIL u_rdata: got %08h expected %08h", u_rdata, e);
            end
         end
      end else if (u_rdata !== 32'h0) begin
         errors++;
         $display("FAIL u_rdata_idle: got %08h expected 00000000", u_rdata);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit port, input bit req, input bit we, input logic [3:0] be,
                        input logic [9:0] addr, input logic [31:0] wdata);
      if (!port) begin
         c_req = req; c_we = we; c_be = be; c_addr = addr; c_wdata = wdata;
      end else begin
         u_req = req; u_we = we; u_be = be; u_addr = addr; u_wdata = wdata;
      end
   endtask

   typedef struct {
      bit          port;
      bit          we;
      logic [3:0]  be;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  exp_mwe;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[12];

   task automatic run_vec(input int idx, input vec_t v);
      @(posedge clk); #1;
      drive(v.port, 1'b1, v.we, v.be, v.addr, v.wdata);
      if (!v.port) cq.push_back(v.exp_rdata); else uq.push_back(v.exp_rdata);
      @(negedge clk);
      chk($sformatf("v%0d c0 m_en", idx), m_en, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d c1 m_en", idx), m_en, 1'b1);
      chk($sformatf("v%0d c1 m_addr", idx), m_addr, v.addr);
      chk($sformatf("v%0d c1 m_we", idx), m_we, v.exp_mwe);
      chk($sformatf("v%0d c1 m_wdata", idx), m_wdata, v.wdata);
      @(negedge clk);
      chk($sformatf("v%0d c2 own_ack", idx), v.port ? u_ack : c_ack, 1'b1);
      chk($sformatf("v%0d c2 other_ack", idx), v.port ? c_ack : u_ack, 1'b0);
      chk($sformatf("v%0d c2 m_en", idx), m_en, 1'b0);
      @(posedge clk); #1;
      drive(v.port, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
   endtask

   initial begin
      bit rr;
      bit exp_c, exp_u;
`ifdef DMEM_ARB_RR_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      vecs[0]  = '{0, 0, 4'b0000, 10'd5,    32'h0,        4'b0000, 32'hDEADBEEF};
      vecs[1]  = '{1, 1, 4'b0010, 10'd3,    32'h0000AB00, 4'b0010, 32'h0};
      vecs[2]  = '{0, 0, 4'b1111, 10'd3,    32'h0,        4'b0000, 32'h1000AB03};
      vecs[3]  = '{1, 0, 4'b1111, 10'd5,    32'h0,        4'b0000, 32'hDEADBEEF};
      vecs[4]  = '{0, 1, 4'b1111, 10'd9,    32'h12345678, 4'b1111, 32'h0};
      vecs[5]  = '{1, 0, 4'b0000, 10'd9,    32'h0,        4'b0000, 32'h12345678};
      vecs[6]  = '{0, 1, 4'b0000, 10'd9,    32'hFFFFFFFF, 4'b0000, 32'h0};
      vecs[7]  = '{0, 0, 4'b0000, 10'd9,    32'h0,        4'b0000, 32'h12345678};
      vecs[8]  = '{0, 1, 4'b1100, 10'd1023, 32'hCAFEF00D, 4'b1100, 32'h0};
      vecs[9]  = '{1, 0, 4'b0000, 10'd1023, 32'h0,        4'b0000, 32'hCAFE03FF};
      vecs[10] = '{1, 1, 4'b0001, 10'd0,    32'h000000EE, 4'b0001, 32'h0};
      vecs[11] = '{0, 0, 4'b0000, 10'd0,    32'h0,        4'b0000, 32'h100000EE};

      rst = 1'b1;
      mem_init = 1'b1;
      drive(0, 0, 0, 4'h0, 10'h0, 32'h0);
      drive(1, 0, 0, 4'h0, 10'h0, 32'h0);
      @(posedge clk); #1;
      mem_init = 1'b0;
      @(negedge clk);
      chk("rst m_en", m_en, 1'b0);
      chk("rst m_we", m_we, 4'b0000);
      chk("rst m_addr", m_addr, 10'h0);
      chk("rst m_wdata", m_wdata, 32'h0);
      chk("rst c_ack", c_ack, 1'b0);
      chk("rst u_ack", u_ack, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle m_en", m_en, 1'b0);

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // CPU keeps req through ack and retargets to addr 7 in the cycle after ack.
      @(posedge clk); #1;
      drive(0, 1, 0, 4'h0, 10'd5, 32'h0);
      cq.push_back(32'hDEADBEEF);
      cq.push_back(32'h10000007);
      @(negedge clk);
      @(negedge clk);
      chk("b2b c1 m_addr", m_addr, 10'd5);
      @(negedge clk);
      chk("b2b c2 c_ack", c_ack, 1'b1);
      @(posedge clk); #1;
      c_addr = 10'd7;
      @(negedge clk);
      chk("b2b c3 m_en", m_en, 1'b0);
      @(negedge clk);
      chk("b2b c4 m_en", m_en, 1'b1);
      chk("b2b c4 m_addr", m_addr, 10'd7);
      @(negedge clk);
      chk("b2b c5 c_ack", c_ack, 1'b1);
      @(posedge clk); #1;
      c_req = 1'b0;

      // Both requesters hold reads from cycle 0.
      @(posedge clk); #1;
      drive(0, 1, 0, 4'h0, 10'd5, 32'h0);
      drive(1, 1, 0, 4'h0, 10'd9, 32'h0);
      for (int k = 0; k < 4; k++) begin
         if (!rr || (k % 2 == 0)) cq.push_back(32'hDEADBEEF);
         else                     uq.push_back(32'h12345678);
      end
      if (!rr) uq.push_back(32'h12345678);
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         exp_c = 1'b0;
         exp_u = 1'b0;
         if (cyc >= 2 && (cyc - 2) % 3 == 0) begin
            if (!rr || (((cyc - 2) / 3) % 2 == 0)) exp_c = 1'b1;
            else                                   exp_u = 1'b1;
         end
         chk($sformatf("arb cyc%0d c_ack", cyc), c_ack, exp_c);
         chk($sformatf("arb cyc%0d u_ack", cyc), u_ack, exp_u);
      end
      @(posedge clk); #1;
      c_req = 1'b0;
      if (rr) u_req = 1'b0;
      for (int cyc = 12; cyc < 15; cyc++) begin
         @(negedge clk);
         chk($sformatf("arb cyc%0d c_ack", cyc), c_ack, 1'b0);
         chk($sformatf("arb cyc%0d u_ack", cyc), u_ack, !rr && cyc == 14);
      end
      @(posedge clk); #1;
      u_req = 1'b0;

      // Reset pulsed during ACCESS; held request re-runs after release.
      @(posedge clk); #1;
      drive(0, 1, 0, 4'h0, 10'd0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("rstacc c1 m_en", m_en, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("rstacc m_en", m_en, 1'b0);
      chk("rstacc m_addr", m_addr, 10'h0);
      chk("rstacc c_ack", c_ack, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstacc post m_en", m_en, 1'b0);
      chk("rstacc post c_ack", c_ack, 1'b0);
      cq.push_back(32'h100000EE);
      @(negedge clk);
      chk("rstacc retry m_en", m_en, 1'b1);
      chk("rstacc retry c_ack", c_ack, 1'b0);
      @(negedge clk);
      chk("rstacc retry ack", c_ack, 1'b1);
      @(posedge clk); #1;
      c_req = 1'b0;

      @(negedge clk);
      chk("cq drained", cq.size(), 0);
      chk("uq drained", uq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
